// File: rtl/mult_array_pipe_if.sv
// mult_array_pipe_if: beat-level bus between distribution network, multiplier array and reduction network
interface mult_array_pipe_if #(
  parameter int IN_DATA_TYPE  = 8,
  parameter int OUT_DATA_TYPE = 24,
  parameter int NUM_PES       = 64
);
  logic                             i_valid;
  logic                             o_ready_in;
  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_data_bus;
  logic                             i_stationary;
  logic [NUM_PES-1:0]               i_lane_mask;
  logic                             i_accum;
  logic                             i_last;
  logic                             o_valid;
  logic                             i_ready_out;
  logic [NUM_PES*OUT_DATA_TYPE-1:0] o_data_bus;
  modport slave (
    input  i_valid, i_data_bus, i_stationary, i_lane_mask, i_accum, i_last, i_ready_out,
    output o_ready_in, o_valid, o_data_bus
  );
  modport master (
    output i_valid, i_data_bus, i_stationary, i_lane_mask, i_accum, i_last, i_ready_out,
    input  o_ready_in, o_valid, o_data_bus
  );
endinterface

// File: rtl/mult_array_pipe.sv
// mult_array_pipe: 1-D stationary-operand multiplier array with masking, backpressure and per-lane accumulate
module mult_array_pipe #(
  parameter int IN_DATA_TYPE  = 8,
  parameter int OUT_DATA_TYPE = 24,
  parameter int NUM_PES       = 64,
  parameter int PIPE_DEPTH    = 2
) (
  input logic              CLK,
  input logic              rst,
  mult_array_pipe_if.slave bus
);
  localparam int IW = IN_DATA_TYPE;
  localparam int OW = OUT_DATA_TYPE;
  typedef logic [NUM_PES-1:0][OW-1:0] lanes_t;
  logic [NUM_PES-1:0][IW-1:0] op, stat;
  lanes_t prod, fin_p, acc, res;
  logic adv, take, valid, fin_v, fin_a, fin_l;
  assign adv            = !valid | bus.i_ready_out;
  assign take           = bus.i_valid & adv;
  assign op             = bus.i_data_bus;
  assign bus.o_ready_in = adv;
  assign bus.o_valid    = valid;
  assign bus.o_data_bus = res;
  always_ff @(posedge CLK or negedge rst)
    if (!rst) stat <= '0;
    else for (int k = 0; k < NUM_PES; k++)
      if (take & bus.i_stationary & bus.i_lane_mask[k]) stat[k] <= op[k];
  // Both operands are sign-extended to OW first, so the truncated product is the exact signed result.
  always_comb begin
    prod = '0;
    for (int k = 0; k < NUM_PES; k++)
      prod[k] = bus.i_lane_mask[k]
        ? OW'({{(OW-IW){stat[k][IW-1]}}, stat[k]} * {{(OW-IW){op[k][IW-1]}}, op[k]})
        : '0;
  end
  generate
    if (PIPE_DEPTH == 1) begin : g_direct
      assign fin_p = prod;
      assign fin_v = take & !bus.i_stationary;
      assign fin_a = bus.i_accum;
      assign fin_l = bus.i_last;
    end else begin : g_pipe
      lanes_t sp [PIPE_DEPTH-1];
      logic [PIPE_DEPTH-2:0] sv, sa, sl;
      always_ff @(posedge CLK or negedge rst)
        if (!rst) begin
          sv <= '0;
          sa <= '0;
          sl <= '0;
          for (int i = 0; i < PIPE_DEPTH-1; i++) sp[i] <= '0;
        end else if (adv) begin
          sv[0] <= take & !bus.i_stationary;
          sa[0] <= bus.i_accum;
          sl[0] <= bus.i_last;
          sp[0] <= prod;
          for (int i = 1; i < PIPE_DEPTH-1; i++) begin
            sv[i] <= sv[i-1];
            sa[i] <= sa[i-1];
            sl[i] <= sl[i-1];
            sp[i] <= sp[i-1];
          end
        end
      assign fin_p = sp[PIPE_DEPTH-2];
      assign fin_v = sv[PIPE_DEPTH-2];
      assign fin_a = sa[PIPE_DEPTH-2];
      assign fin_l = sl[PIPE_DEPTH-2];
    end
  endgenerate
  // Final stage doubles as the output register; res holds its value while no beat is emitted.
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      res   <= '0;
      acc   <= '0;
    end else if (adv) begin
      valid <= fin_v & (!fin_a | fin_l);
      if (fin_v)
        for (int k = 0; k < NUM_PES; k++)
          if (!fin_a) res[k] <= fin_p[k];
          else if (fin_l) begin
            res[k] <= acc[k] + fin_p[k];
            acc[k] <= '0;
          end else acc[k] <= acc[k] + fin_p[k];
    end
endmodule

// File: tb/tb_mult_array_pipe.sv
// tb_mult_array_pipe: directed vectors for a 4-lane, 8x8->24, depth-2 array
module tb_mult_array_pipe;
  localparam int N = 4, IW = 8, OW = 24;
  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;
  mult_array_pipe_if #(.IN_DATA_TYPE(IW), .OUT_DATA_TYPE(OW), .NUM_PES(N)) bus ();
  mult_array_pipe #(.IN_DATA_TYPE(IW), .OUT_DATA_TYPE(OW), .NUM_PES(N), .PIPE_DEPTH(2)) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    int         st[4];
    logic [3:0] sm;
    int         d[4];
    logic [3:0] m;
    int         e[4];
  } vec_t;
  vec_t tv[5];
  int cmp = 0, bad = 0;
  int z[4] = '{0, 0, 0, 0};
  function automatic logic [N*IW-1:0] pk(input int a[4]);
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(a[k]);
    return r;
  endfunction
  function automatic logic [N*OW-1:0] pko(input int a[4]);
    logic [N*OW-1:0] r;
    for (int k = 0; k < N; k++) r[k*OW +: OW] = OW'(a[k]);
    return r;
  endfunction
  function automatic logic [N*OW-1:0] ramp(input int n);
    int a[4];
    for (int k = 0; k < N; k++) a[k] = (k + 1) * n;
    return pko(a);
  endfunction
  task automatic chk(input string nm, input logic [N*OW-1:0] got, input logic [N*OW-1:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic s, input logic [3:0] m, input int d[4], input logic a, input logic l);
    bus.i_valid      = v;
    bus.i_stationary = s;
    bus.i_lane_mask  = m;
    bus.i_data_bus   = pk(d);
    bus.i_accum      = a;
    bus.i_last       = l;
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic beat(input logic s, input logic [3:0] m, input int d[4], input logic a, input logic l);
    drive(1'b1, s, m, d, a, l);
    tick();
  endtask
  task automatic idle;
    drive(1'b0, 1'b0, 4'hF, z, 1'b0, 1'b0);
    tick();
  endtask
  task automatic cbeat(input int n);
    int a[4];
    for (int k = 0; k < N; k++) a[k] = n;
    drive(1'b1, 1'b0, 4'hF, a, 1'b0, 1'b0);
  endtask
  initial begin
    int c1[4], c2[4], c5[4], c7[4], n128[4];
    logic seen;
    c1 = '{1, 1, 1, 1};
    c2 = '{2, 2, 2, 2};
    c5 = '{5, 5, 5, 5};
    c7 = '{7, 7, 7, 7};
    n128 = '{-128, -128, -128, -128};
    tv[0] = '{'{3, -2, 127, -128}, 4'hF, '{4, 4, -128, -128}, 4'hF, '{12, -8, -16256, 16384}};
    tv[1] = '{'{3, 3, 3, 3},       4'hF, '{1, 1, 1, 1},       4'b0101, '{3, 0, 3, 0}};
    tv[2] = '{'{9, 9, 9, 9},       4'b0010, '{1, 1, 1, 1},    4'hF, '{3, 9, 3, 3}};
    tv[3] = '{'{-1, -1, 100, -7},  4'hF, '{-1, 127, -100, 0}, 4'hF, '{1, -127, -10000, 0}};
    tv[4] = '{'{50, 50, 50, 50},   4'h0, '{2, 2, 2, 2},       4'hF, '{-2, -2, 200, -14}};
    rst = 1'b1;
    bus.i_ready_out = 1'b1;
    drive(1'b0, 1'b0, 4'hF, z, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("reset_valid", bus.o_valid, 1'b0);
    chk("reset_data", bus.o_data_bus, '0);
    chk("reset_ready", bus.o_ready_in, 1'b1);
    @(negedge CLK) rst = 1'b1;
    beat(1'b1, 4'hF, c1, 1'b0, 1'b0);
    beat(1'b0, 4'hF, c7, 1'b0, 1'b0);
    beat(1'b0, 4'hF, c7, 1'b0, 1'b0);
    chk("pre_reset_valid", bus.o_valid, 1'b1);
    chk("pre_reset_data", bus.o_data_bus, pko(c7));
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_valid", bus.o_valid, 1'b0);
    chk("mid_reset_data", bus.o_data_bus, '0);
    chk("mid_reset_ready", bus.o_ready_in, 1'b1);
    @(negedge CLK) rst = 1'b1;
    tick();
    beat(1'b0, 4'hF, c5, 1'b0, 1'b0);
    idle();
    chk("post_reset_valid", bus.o_valid, 1'b1);
    chk("post_reset_data", bus.o_data_bus, '0);
    idle();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, tv[i].sm, tv[i].st, 1'b0, 1'b0);
      beat(1'b0, tv[i].m, tv[i].d, 1'b0, 1'b0);
      idle();
      chk($sformatf("vec%0d_valid", i), bus.o_valid, 1'b1);
      chk($sformatf("vec%0d_data", i), bus.o_data_bus, pko(tv[i].e));
      idle();
      chk($sformatf("vec%0d_drop", i), bus.o_valid, 1'b0);
    end
    beat(1'b1, 4'hF, '{1, 2, 3, 4}, 1'b0, 1'b0);
    cbeat(1);
    tick();
    cbeat(2);
    tick();
    bus.i_ready_out = 1'b0;
    cbeat(3);
    #1;
    chk("bp_ready", bus.o_ready_in, 1'b0);
    chk("bp_valid", bus.o_valid, 1'b1);
    chk("bp_data", bus.o_data_bus, ramp(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_ready", i), bus.o_ready_in, 1'b0);
      chk($sformatf("bp_hold%0d_valid", i), bus.o_valid, 1'b1);
      chk($sformatf("bp_hold%0d_data", i), bus.o_data_bus, ramp(1));
    end
    bus.i_ready_out = 1'b1;
    tick();
    chk("bp_out2_valid", bus.o_valid, 1'b1);
    chk("bp_out2", bus.o_data_bus, ramp(2));
    cbeat(4);
    tick();
    chk("bp_out3", bus.o_data_bus, ramp(3));
    idle();
    chk("bp_out4_valid", bus.o_valid, 1'b1);
    chk("bp_out4", bus.o_data_bus, ramp(4));
    idle();
    chk("bp_no_extra", bus.o_valid, 1'b0);
    beat(1'b1, 4'hF, '{2, 2, 2, 2}, 1'b0, 1'b0);
    beat(1'b0, 4'hF, c1, 1'b1, 1'b0);
    beat(1'b0, 4'hF, c2, 1'b1, 1'b0);
    chk("acc_quiet1", bus.o_valid, 1'b0);
    beat(1'b0, 4'hF, '{3, 3, 3, 3}, 1'b1, 1'b1);
    chk("acc_quiet2", bus.o_valid, 1'b0);
    idle();
    chk("acc_valid", bus.o_valid, 1'b1);
    chk("acc_sum", bus.o_data_bus, pko('{12, 12, 12, 12}));
    beat(1'b0, 4'hF, c1, 1'b1, 1'b1);
    chk("acc_hold", bus.o_valid, 1'b0);
    idle();
    chk("acc_clear_valid", bus.o_valid, 1'b1);
    chk("acc_clear", bus.o_data_bus, pko(c2));
    beat(1'b1, 4'hF, n128, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      beat(1'b0, 4'hF, n128, 1'b1, i == 599);
      seen |= bus.o_valid;
    end
    chk("wrap_quiet", seen, 1'b0);
    idle();
    chk("wrap_valid", bus.o_valid, 1'b1);
    chk("wrap_sum", bus.o_data_bus, {N{24'h960000}});
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
